// File: rtl/systolic_kv_pq_if.sv
// systolic_kv_pq_if: request/status bundle between the open-list queue and its user.
interface systolic_kv_pq_if #(
  parameter int KEY_W = 32,
  parameter int VAL_W = 16,
  parameter int CNT_W = 4
);
  logic             enq;
  logic             deq;
  logic             clr;
  logic [KEY_W-1:0] key;
  logic [VAL_W-1:0] val;
  logic             ready;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic [KEY_W-1:0] top_key;
  logic [VAL_W-1:0] top_val;
  logic             ovf;
  logic             udf;
  modport master (
    output enq, deq, clr, key, val,
    input  ready, empty, full, count, top_key, top_val, ovf, udf
  );
  modport slave (
    input  enq, deq, clr, key, val,
    output ready, empty, full, count, top_key, top_val, ovf, udf
  );
endinterface

// File: rtl/systolic_kv_pq.sv
// systolic_kv_pq: IB/OB key-value priority queue (min or max) with replace, clear and a ready handshake.
module systolic_kv_pq #(
  parameter int DEPTH    = 4,
  parameter int KEY_W    = 32,
  parameter int VAL_W    = 16,
  parameter int MAX_MODE = 0,
  parameter int CNT_W    = $clog2(2 * DEPTH + 1)
) (
  input logic             clk,
  input logic             rst,
  systolic_kv_pq_if.slave bus
);
  localparam int CAP = 2 * DEPTH;
  localparam int L   = CAP - 1;
  typedef struct packed {
    logic             ok;
    logic [KEY_W-1:0] k;
    logic [VAL_W-1:0] v;
  } slot_t;
  typedef enum logic {READY, SETTLE} state_t;
  // q[0..DEPTH-1] are OB of cells 0..DEPTH-1; q[DEPTH..L] are IB of cells DEPTH-1..0, so IB[0] = q[L]
  slot_t            q     [CAP];
  slot_t            q_nxt [CAP];
  slot_t            u     [CAP];
  logic [CAP-1:0]   bx;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             ovf, udf, go, push, pop, full, empty;

  function automatic logic better(slot_t a, slot_t b);
    return a.ok && (!b.ok || (MAX_MODE != 0 ? a.k > b.k : a.k < b.k));
  endfunction

  assign full  = count == CNT_W'(CAP);
  assign empty = count == '0;
  assign go    = state == READY && (bus.enq || bus.deq || bus.clr);
  assign pop   = go && !bus.clr && bus.deq && !empty;
  assign push  = go && !bus.clr && bus.enq && (!full || bus.deq);

  // The cells ahead of IB[0] stay ordered, so the newcomer in IB[0] lands where it first beats a slot
  always_comb begin
    bx[L] = 1'b1;
    for (int j = 0; j < L; j++) bx[j] = better(q[L], q[j]);
    u[0] = bx[0] ? q[L] : q[0];
    for (int j = 1; j < CAP; j++) u[j] = bx[j-1] ? q[j-1] : (bx[j] ? q[L] : q[j]);
  end

  always_comb begin
    q_nxt     = u;
    count_nxt = count;
    state_nxt = (state == READY && (bus.clr || push || pop)) ? SETTLE : READY;
    if (go && bus.clr) begin
      q_nxt     = '{default: '0};
      count_nxt = '0;
    end else begin
      if (pop) begin
        for (int j = 0; j < L; j++) q_nxt[j] = q[j+1];
        q_nxt[L] = '0;
      end
      if (push) q_nxt[L] = '{ok: 1'b1, k: bus.key, v: bus.val};
      count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= READY;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
      q     <= '{default: '0};
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      ovf   <= go && !bus.clr && bus.enq && !bus.deq && full;
      udf   <= go && !bus.clr && bus.deq && empty;
      q     <= q_nxt;
    end
  end

  assign bus.ready   = state == READY;
  assign bus.empty   = empty;
  assign bus.full    = full;
  assign bus.count   = count;
  assign bus.top_key = q[0].ok ? q[0].k : '0;
  assign bus.top_val = q[0].ok ? q[0].v : '0;
  assign bus.ovf     = ovf;
  assign bus.udf     = udf;
endmodule

// File: tb/tb_systolic_kv_pq.sv
// tb_systolic_kv_pq: vector table plus corner sequences against a min-queue and a max-queue instance.
module tb_systolic_kv_pq;
  localparam int D  = 4;
  localparam int KW = 32;
  localparam int VW = 16;
  localparam int CW = $clog2(2 * D + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_kv_pq_if #(.KEY_W(KW), .VAL_W(VW), .CNT_W(CW)) b0 ();
  systolic_kv_pq_if #(.KEY_W(KW), .VAL_W(VW), .CNT_W(CW)) b1 ();
  systolic_kv_pq #(.DEPTH(D), .KEY_W(KW), .VAL_W(VW), .MAX_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  systolic_kv_pq #(.DEPTH(D), .KEY_W(KW), .VAL_W(VW), .MAX_MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct {
    logic [KW-1:0] k;
    logic [VW-1:0] v;
  } kv_t;
  typedef struct {
    bit            m, e, d, c;
    logic [KW-1:0] k;
    logic [VW-1:0] v;
    int            cnt;
    bit            ovf, udf, stay;
    logic [KW-1:0] top;
  } vec_t;

  kv_t  model[$];
  vec_t tv[$];
  int   errors = 0;
  int   checks = 0;
  bit   msel = 1'b0;

  logic          rdy, emp, ful, ovf, udf;
  logic [CW-1:0] cnt;
  logic [KW-1:0] tk;
  logic [VW-1:0] tval;
  assign rdy  = msel ? b1.ready   : b0.ready;
  assign emp  = msel ? b1.empty   : b0.empty;
  assign ful  = msel ? b1.full    : b0.full;
  assign ovf  = msel ? b1.ovf     : b0.ovf;
  assign udf  = msel ? b1.udf     : b0.udf;
  assign cnt  = msel ? b1.count   : b0.count;
  assign tk   = msel ? b1.top_key : b0.top_key;
  assign tval = msel ? b1.top_val : b0.top_val;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input bit m, input bit e, d, c, input logic [KW-1:0] k, input logic [VW-1:0] v);
    if (m) begin
      b1.enq = e; b1.deq = d; b1.clr = c; b1.key = k; b1.val = v;
    end else begin
      b0.enq = e; b0.deq = d; b0.clr = c; b0.key = k; b0.val = v;
    end
  endtask

  task automatic wait_ready(input string nm);
    for (int i = 0; i < 5 && !rdy; i++) begin
      @(posedge clk);
      #1;
    end
    chk({nm, " ready timeout"}, 64'(rdy), 64'd1);
  endtask

  task automatic apply(input vec_t t, input int idx);
    string nm;
    bit    was_empty, was_full;
    int    bi;
    nm        = $sformatf("v%0d", idx);
    msel      = t.m;
    was_empty = model.size() == 0;
    was_full  = model.size() == 2 * D;
    if (t.c) model.delete();
    else begin
      if (t.d && !was_empty) begin
        bi = 0;
        for (int i = 1; i < model.size(); i++)
          if (t.m ? model[i].k > model[bi].k : model[i].k < model[bi].k) bi = i;
        chk({nm, " pop key"}, 64'(tk), 64'(model[bi].k));
        chk({nm, " pop val"}, 64'(tval), 64'(model[bi].v));
        model.delete(bi);
      end
      if (t.e && (!was_full || t.d)) model.push_back('{k: t.k, v: t.v});
    end
    set_in(t.m, t.e, t.d, t.c, t.k, t.v);
    @(posedge clk);
    #1;
    set_in(t.m, 0, 0, 0, '0, '0);
    chk({nm, " ovf"}, 64'(ovf), 64'(t.ovf));
    chk({nm, " udf"}, 64'(udf), 64'(t.udf));
    chk({nm, " count"}, 64'(cnt), 64'(t.cnt));
    chk({nm, " ready"}, 64'(rdy), 64'(t.stay));
    chk({nm, " empty"}, 64'(emp), 64'(t.cnt == 0));
    chk({nm, " full"}, 64'(ful), 64'(t.cnt == 2 * D));
    wait_ready(nm);
    chk({nm, " top"}, 64'(tk), 64'(t.top));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    set_in(0, 0, 0, 0, '0, '0);
    set_in(1, 0, 0, 0, '0, '0);
    rst = 1'b1;
    // m  e  d  c  key           val      cnt ovf udf stay top
    tv.push_back('{0, 1, 0, 0, 5,            16'hA,   1, 0, 0, 0, 5});
    tv.push_back('{0, 1, 0, 0, 3,            16'hB,   2, 0, 0, 0, 3});
    tv.push_back('{0, 1, 0, 0, 9,            16'hC,   3, 0, 0, 0, 3});
    tv.push_back('{0, 1, 0, 0, 1,            16'hD,   4, 0, 0, 0, 1});
    tv.push_back('{0, 0, 1, 0, 0,            0,       3, 0, 0, 0, 3});
    tv.push_back('{0, 0, 1, 0, 0,            0,       2, 0, 0, 0, 5});
    tv.push_back('{0, 0, 1, 0, 0,            0,       1, 0, 0, 0, 9});
    tv.push_back('{0, 0, 1, 0, 0,            0,       0, 0, 0, 0, 0});
    tv.push_back('{0, 0, 1, 0, 0,            0,       0, 0, 1, 1, 0});
    tv.push_back('{0, 1, 1, 0, 7,            16'h77,  1, 0, 1, 0, 7});
    tv.push_back('{0, 1, 0, 0, 20,           16'h14,  2, 0, 0, 0, 7});
    tv.push_back('{0, 1, 0, 0, 15,           16'h0F,  3, 0, 0, 0, 7});
    tv.push_back('{0, 1, 0, 0, 30,           16'h1E,  4, 0, 0, 0, 7});
    tv.push_back('{0, 1, 0, 0, 12,           16'h0C,  5, 0, 0, 0, 7});
    tv.push_back('{0, 1, 0, 0, 25,           16'h19,  6, 0, 0, 0, 7});
    tv.push_back('{0, 1, 0, 0, 40,           16'h28,  7, 0, 0, 0, 7});
    tv.push_back('{0, 1, 0, 0, 4,            16'h04,  8, 0, 0, 0, 4});
    tv.push_back('{0, 1, 0, 0, 50,           16'h32,  8, 1, 0, 1, 4});
    tv.push_back('{0, 1, 1, 0, 0,            16'hF0,  8, 0, 0, 0, 0});
    tv.push_back('{0, 0, 1, 0, 0,            0,       7, 0, 0, 0, 7});
    tv.push_back('{0, 0, 1, 0, 0,            0,       6, 0, 0, 0, 12});
    tv.push_back('{0, 0, 1, 0, 0,            0,       5, 0, 0, 0, 15});
    tv.push_back('{0, 1, 0, 0, 13,           16'h0D,  6, 0, 0, 0, 13});
    tv.push_back('{0, 1, 0, 1, 99,           16'h63,  0, 0, 0, 0, 0});
    tv.push_back('{1, 1, 0, 0, 32'hFFFFFFFF, 16'h1,   1, 0, 0, 0, 32'hFFFFFFFF});
    tv.push_back('{1, 1, 0, 0, 0,            16'h2,   2, 0, 0, 0, 32'hFFFFFFFF});
    tv.push_back('{1, 1, 0, 0, 42,           16'h3,   3, 0, 0, 0, 32'hFFFFFFFF});
    tv.push_back('{1, 0, 1, 0, 0,            0,       2, 0, 0, 0, 42});
    tv.push_back('{1, 0, 1, 0, 0,            0,       1, 0, 0, 0, 0});
    tv.push_back('{1, 0, 1, 0, 0,            0,       0, 0, 0, 0, 0});

    @(posedge clk);
    #1;
    chk("reset empty", 64'(emp), 64'd1);
    chk("reset full", 64'(ful), 64'd0);
    chk("reset count", 64'(cnt), 64'd0);
    chk("reset top", 64'(tk), 64'd0);
    chk("reset ready", 64'(rdy), 64'd1);
    chk("reset pulses", 64'({ovf, udf}), 64'd0);
    rst = 1'b0;

    foreach (tv[i]) apply(tv[i], i);

    // a request held across SETTLE is taken only on READY edges
    msel = 1'b0;
    set_in(0, 1, 0, 0, 50, 16'h5);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("held ready %0d", i), 64'(rdy), 64'(i % 2));
    end
    set_in(0, 0, 0, 0, '0, '0);
    chk("held count", 64'(cnt), 64'd2);
    model.push_back('{k: 50, v: 16'h5});
    model.push_back('{k: 50, v: 16'h5});
    apply('{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0}, 100);

    // asynchronous reset while holding three entries
    apply('{0, 1, 0, 0, 10, 16'h1, 1, 0, 0, 0, 10}, 101);
    apply('{0, 1, 0, 0, 11, 16'h2, 2, 0, 0, 0, 10}, 102);
    apply('{0, 1, 0, 0, 6,  16'h3, 3, 0, 0, 0, 6}, 103);
    #2 rst = 1'b1;
    #1;
    chk("async rst empty", 64'(emp), 64'd1);
    chk("async rst count", 64'(cnt), 64'd0);
    chk("async rst top", 64'(tk), 64'd0);
    chk("async rst ready", 64'(rdy), 64'd1);
    model.delete();
    @(negedge clk);
    rst = 1'b0;
    apply('{0, 1, 0, 0, 8, 16'h8, 1, 0, 0, 0, 8}, 104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
